// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply operand path: default sizes and
// the operand feeder state encoding.
package mm_pkg;

    localparam int MM_DATA_WIDTH   = 8;
    localparam int MM_N            = 4;
    localparam int MM_COUNTER_BITS = 16;
    localparam int MM_MAX_LEN      = 64;

    // state      | meaning
    // ST_IDLE    | waiting for start, buffers writable
    // ST_STREAM  | presenting beat k until accepted
    // ST_DONE    | one-cycle completion pulse, then back to idle
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } mm_state_e;

endpackage

// File: rtl/mm_operand_feeder_buffer.sv
// Operand register file: MAX_LEN beats of N elements, one write port and a
// combinational read port so the addressed beat is visible in the same cycle.
module operand_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int N          = 4,
    parameter int MAX_LEN    = 64,
    parameter int KW         = $clog2(MAX_LEN)
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [KW-1:0]                  wr_k,
    input  logic [N-1:0][DATA_WIDTH-1:0]   wr_data,
    input  logic [KW-1:0]                  rd_k,
    output logic [N-1:0][DATA_WIDTH-1:0]   rd_data
);

    // Contents are deliberately not reset so a loaded operand survives job
    // aborts and can be streamed repeatedly.
    logic [N-1:0][DATA_WIDTH-1:0] mem_q [MAX_LEN];

    // Write the addressed beat; out-of-range indices are dropped.
    always_ff @(posedge clk) begin
        if (we && (int'(wr_k) < MAX_LEN)) begin
            mem_q[wr_k] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_k];

endmodule

// File: rtl/mm_operand_feeder.sv
// Operand feeder: holds A columns and B rows in two buffers and streams beat
// k = 0..len-1 to the systolic multiplier with a valid/ready handshake.
module mm_operand_feeder
    import mm_pkg::*;
#(
    parameter int DATA_WIDTH   = MM_DATA_WIDTH,
    parameter int N            = MM_N,
    parameter int COUNTER_BITS = MM_COUNTER_BITS,
    parameter int MAX_LEN      = MM_MAX_LEN
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           wr_en,
    input  logic                           wr_sel,
    input  logic [$clog2(MAX_LEN)-1:0]     wr_k,
    input  logic [N-1:0][DATA_WIDTH-1:0]   wr_data,
    input  logic                           start,
    input  logic [COUNTER_BITS-1:0]        len,
    output logic                           busy,
    output logic                           done,
    output logic                           err,
    output logic                           a_input_valid,
    output logic                           b_input_valid,
    input  logic                           input_ready,
    output logic [COUNTER_BITS-1:0]        len_input,
    output logic [N-1:0][DATA_WIDTH-1:0]   a_data,
    output logic [N-1:0][DATA_WIDTH-1:0]   b_data
);

    localparam int KW = $clog2(MAX_LEN);

    mm_state_e                    state_q;
    logic [KW-1:0]                k_q;
    logic [COUNTER_BITS-1:0]      len_q;
    logic                         busy_q;
    logic                         done_q;
    logic                         err_q;
    logic                         valid_q;

    logic [N-1:0][DATA_WIDTH-1:0] a_rd;
    logic [N-1:0][DATA_WIDTH-1:0] b_rd;
    logic                         wr_ok;
    logic                         xfer;
    logic                         last_beat;
    logic                         len_ok;

    // Buffers only accept writes while idle so a running job sees a frozen operand.
    assign wr_ok     = wr_en && (state_q == ST_IDLE);
    assign xfer      = valid_q && input_ready;
    assign last_beat = (COUNTER_BITS'(k_q) == (len_q - COUNTER_BITS'(1)));
    assign len_ok    = (len != '0) && (len <= COUNTER_BITS'(MAX_LEN));

    operand_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .N          (N),
        .MAX_LEN    (MAX_LEN),
        .KW         (KW)
    ) u_buf_a (
        .clk     (clk),
        .we      (wr_ok && !wr_sel),
        .wr_k    (wr_k),
        .wr_data (wr_data),
        .rd_k    (k_q),
        .rd_data (a_rd)
    );

    operand_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .N          (N),
        .MAX_LEN    (MAX_LEN),
        .KW         (KW)
    ) u_buf_b (
        .clk     (clk),
        .we      (wr_ok && wr_sel),
        .wr_k    (wr_k),
        .wr_data (wr_data),
        .rd_k    (k_q),
        .rd_data (b_rd)
    );

    // Job sequencer with registered status outputs; done/err are single-cycle pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            len_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (len_ok) begin
                            state_q <= ST_STREAM;
                            len_q   <= len;
                            k_q     <= '0;
                            busy_q  <= 1'b1;
                            valid_q <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_STREAM: begin
                    if (xfer) begin
                        if (last_beat) begin
                            state_q <= ST_DONE;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            k_q <= k_q + KW'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    len_q   <= '0;
                    k_q     <= '0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                    len_q   <= '0;
                    k_q     <= '0;
                end
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign a_input_valid = valid_q;
    assign b_input_valid = valid_q;
    assign len_input     = len_q;
    assign a_data        = valid_q ? a_rd : '0;
    assign b_data        = valid_q ? b_rd : '0;

endmodule

// File: tb/tb_mm_operand_feeder.sv
// Directed bench for mm_operand_feeder with N=4, MAX_LEN=64.
module tb_mm_operand_feeder;
    import mm_pkg::*;

    localparam int DW = 8;
    localparam int NN = 4;
    localparam int CB = 16;
    localparam int ML = 64;
    localparam int KW = 6;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   wr_en;
    logic                   wr_sel;
    logic [KW-1:0]          wr_k;
    logic [NN-1:0][DW-1:0]  wr_data;
    logic                   start;
    logic [CB-1:0]          len;
    logic                   busy;
    logic                   done;
    logic                   err;
    logic                   a_input_valid;
    logic                   b_input_valid;
    logic                   input_ready;
    logic [CB-1:0]          len_input;
    logic [NN-1:0][DW-1:0]  a_data;
    logic [NN-1:0][DW-1:0]  b_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mm_operand_feeder #(
        .DATA_WIDTH (DW), .N (NN), .COUNTER_BITS (CB), .MAX_LEN (ML)
    ) dut (
        .clk (clk), .reset (reset), .wr_en (wr_en), .wr_sel (wr_sel),
        .wr_k (wr_k), .wr_data (wr_data), .start (start), .len (len),
        .busy (busy), .done (done), .err (err),
        .a_input_valid (a_input_valid), .b_input_valid (b_input_valid),
        .input_ready (input_ready), .len_input (len_input),
        .a_data (a_data), .b_data (b_data)
    );

    typedef struct packed {
        logic        rdy;
        logic        vld;
        logic [31:0] a;
        logic [31:0] b;
        logic        dn;
        logic        bsy;
        logic [15:0] li;
    } vec_t;

    vec_t tbl [11];

    localparam logic [31:0] ACOL0 = 32'h04030201;
    localparam logic [31:0] ACOL1 = 32'h08070605;
    localparam logic [31:0] ACOL2 = 32'h0C0B0A09;
    localparam logic [31:0] ACOL3 = 32'h100F0E0D;
    localparam logic [31:0] BROW0 = 32'h00000001;
    localparam logic [31:0] BROW1 = 32'h00000100;
    localparam logic [31:0] BROW2 = 32'h00010000;
    localparam logic [31:0] BROW3 = 32'h01000000;

    logic [31:0] acol [4];
    logic [31:0] brow [4];
    logic [31:0] brnd [4];
    int          cmat [4][4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic sel, input int k, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_k    = KW'(k);
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic start_job(input int l);
        start = 1'b1;
        len   = CB'(l);
        tick();
        start = 1'b0;
        len   = '0;
    endtask

    task automatic run_table(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            input_ready = tbl[i].rdy;
            chk("a_valid", a_input_valid, tbl[i].vld);
            chk("b_valid", b_input_valid, tbl[i].vld);
            chk("a_data", a_data, tbl[i].a);
            chk("b_data", b_data, tbl[i].b);
            chk("done", done, tbl[i].dn);
            chk("busy", busy, tbl[i].bsy);
            chk("len_input", len_input, tbl[i].li);
            tick();
        end
    endtask

    initial begin
        int cyc;
        int ndone;

        // rdy vld a b done busy len_input; job len=2, ready held high
        tbl[0]  = '{1'b1, 1'b1, ACOL0, BROW0, 1'b0, 1'b1, 16'd2};
        tbl[1]  = '{1'b1, 1'b1, ACOL1, BROW1, 1'b0, 1'b1, 16'd2};
        tbl[2]  = '{1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 16'd2};
        tbl[3]  = '{1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 16'd0};
        // same job, ready toggling 0,1,0,0,1
        tbl[4]  = '{1'b0, 1'b1, ACOL0, BROW0, 1'b0, 1'b1, 16'd2};
        tbl[5]  = '{1'b1, 1'b1, ACOL0, BROW0, 1'b0, 1'b1, 16'd2};
        tbl[6]  = '{1'b0, 1'b1, ACOL1, BROW1, 1'b0, 1'b1, 16'd2};
        tbl[7]  = '{1'b0, 1'b1, ACOL1, BROW1, 1'b0, 1'b1, 16'd2};
        tbl[8]  = '{1'b1, 1'b1, ACOL1, BROW1, 1'b0, 1'b1, 16'd2};
        tbl[9]  = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 16'd2};
        tbl[10] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 16'd0};

        acol[0] = ACOL0; acol[1] = ACOL1; acol[2] = ACOL2; acol[3] = ACOL3;
        brow[0] = BROW0; brow[1] = BROW1; brow[2] = BROW2; brow[3] = BROW3;

        reset = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_k = '0; wr_data = '0;
        start = 1'b0; len = '0; input_ready = 1'b0;
        tick(); tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_valid", a_input_valid, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_len_input", len_input, 16'd0);
        chk("rst_a_data", a_data, 32'h0);
        reset = 1'b0;
        tick();

        for (int k = 0; k < 4; k++) begin
            wr(1'b0, k, acol[k]);
            wr(1'b1, k, brow[k]);
        end

        start_job(2);
        run_table(0, 3);
        start_job(2);
        run_table(4, 10);

        // rejected lengths
        start_job(0);
        chk("err_len0", err, 1'b1);
        chk("busy_len0", busy, 1'b0);
        chk("valid_len0", a_input_valid, 1'b0);
        tick();
        chk("err_clear0", err, 1'b0);
        start_job(65);
        chk("err_len65", err, 1'b1);
        chk("busy_len65", busy, 1'b0);
        chk("valid_len65", a_input_valid, 1'b0);
        tick();
        chk("err_clear65", err, 1'b0);

        // upper boundary is accepted; abort with reset
        start_job(64);
        chk("err_len64", err, 1'b0);
        chk("busy_len64", busy, 1'b1);
        chk("len_input64", len_input, 16'd64);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("busy_abort64", busy, 1'b0);

        // write and start during STREAM are ignored
        input_ready = 1'b0;
        start_job(2);
        wr(1'b1, 0, 32'h09090909);
        chk("b0_hold_stream", b_data, BROW0);
        chk("a0_hold_stream", a_data, ACOL0);
        start_job(5);
        chk("err_start_stream", err, 1'b0);
        chk("len_keep_stream", len_input, 16'd2);
        input_ready = 1'b1;
        tick(); tick();
        chk("done_midwr", done, 1'b1);
        tick();
        start_job(2);
        chk("b0_after_drop", b_data, BROW0);
        tick(); tick(); tick();
        chk("idle_after_drop", busy, 1'b0);

        // reset on the 2nd beat of a len=4 job
        input_ready = 1'b1;
        start_job(4);
        chk("rst4_beat0", a_data, ACOL0);
        tick();
        chk("rst4_beat1", a_data, ACOL1);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("abort_valid", a_input_valid, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_a", a_data, 32'h0);
        chk("abort_b", b_data, 32'h0);
        chk("abort_len", len_input, 16'd0);
        tick();
        chk("abort_done2", done, 1'b0);
        start_job(4);
        for (int k = 0; k < 4; k++) begin
            chk("rerun_a", a_data, acol[k]);
            chk("rerun_b", b_data, brow[k]);
            tick();
        end
        chk("rerun_done", done, 1'b1);
        tick();

        // end to end: A = identity, B random, C = A*B must equal B
        for (int k = 0; k < 4; k++) begin
            brnd[k] = $urandom;
            wr(1'b0, k, 32'h1 << (8 * k));
            wr(1'b1, k, brnd[k]);
            for (int j = 0; j < 4; j++) cmat[k][j] = 0;
        end
        input_ready = 1'b1;
        start_job(4);
        ndone = 0;
        cyc = 0;
        while (busy && cyc < 20) begin
            if (a_input_valid && input_ready) begin
                for (int i = 0; i < 4; i++)
                    for (int j = 0; j < 4; j++)
                        cmat[i][j] += int'(a_data[i]) * int'(b_data[j]);
            end
            if (done) ndone++;
            tick();
            cyc++;
        end
        chk("e2e_timeout", (cyc < 20), 1'b1);
        chk("e2e_done_count", ndone, 1);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                chk("e2e_c", cmat[i][j], {56'h0, brnd[i][8*j +: 8]});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
